// File: rtl/ysyx_22040237_seq_ctrl_if.sv
// Handshake, decode-flag, strobe and status bundle between the NPC sequencer and the core datapath.
// master is the sequencer side; slave is the datapath/memory side.
interface ysyx_22040237_seq_ctrl_if;
    logic        start;
    logic        ifu_req;
    logic        ifu_ack;
    logic        inst_is_load;
    logic        inst_is_store;
    logic        inst_ebreak;
    logic        invalid_inst;
    logic        lsu_req;
    logic        lsu_ack;
    logic        ir_we;
    logic        rf_we;
    logic        pc_we;
    logic        halted;
    logic [1:0]  halt_code;
    logic [2:0]  state;
    logic [63:0] retire_cnt;

    modport master (
        input  start, ifu_ack, inst_is_load, inst_is_store, inst_ebreak, invalid_inst, lsu_ack,
        output ifu_req, lsu_req, ir_we, rf_we, pc_we, halted, halt_code, state, retire_cnt
    );

    modport slave (
        output start, ifu_ack, inst_is_load, inst_is_store, inst_ebreak, invalid_inst, lsu_ack,
        input  ifu_req, lsu_req, ir_we, rf_we, pc_we, halted, halt_code, state, retire_cnt
    );
endinterface

// File: rtl/ysyx_22040237_seq_ctrl.sv
// Multi-cycle NPC sequencer: FETCH/DECODE/EXEC/[MEM]/WB with a memory-wait watchdog.
// Stops permanently on ebreak, illegal decode or watchdog expiry.
module ysyx_22040237_seq_ctrl #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    ysyx_22040237_seq_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT_W'(TIMEOUT);

    state_t               r_state, w_state_nxt;
    logic                 r_mem_op, r_store_op;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic [1:0]           r_halt_code, w_halt_code_nxt;
    logic [63:0]          r_retire_cnt;
    logic                 w_wait_inc, w_latch_dec, w_timeout;

    assign w_timeout = (r_wait_cnt == TO_VAL);

    always_comb begin
        w_state_nxt     = r_state;
        w_halt_code_nxt = r_halt_code;
        w_wait_inc      = 1'b0;
        w_latch_dec     = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH: begin
                // an ack in the expiry cycle still wins over the watchdog
                if (bus.ifu_ack) w_state_nxt = S_DECODE;
                else if (w_timeout) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = 2'd3;
                end else w_wait_inc = 1'b1;
            end
            S_DECODE: begin
                if (bus.invalid_inst || (bus.inst_is_load && bus.inst_is_store)) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = 2'd2;
                end else if (bus.inst_ebreak) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = 2'd1;
                end else begin
                    w_state_nxt = S_EXEC;
                    w_latch_dec = 1'b1;
                end
            end
            S_EXEC:   w_state_nxt = r_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.lsu_ack) w_state_nxt = S_WB;
                else if (w_timeout) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = 2'd3;
                end else w_wait_inc = 1'b1;
            end
            S_WB:     w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_halt_code  <= 2'd0;
            r_mem_op     <= 1'b0;
            r_store_op   <= 1'b0;
            r_wait_cnt   <= '0;
            r_retire_cnt <= 64'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_halt_code <= w_halt_code_nxt;
            if (w_latch_dec) begin
                r_mem_op   <= bus.inst_is_load | bus.inst_is_store;
                r_store_op <= bus.inst_is_store;
            end
            // counter only runs while waiting, so it is zero on every entry to FETCH/MEM
            r_wait_cnt <= w_wait_inc ? r_wait_cnt + 1'b1 : '0;
            if (r_state == S_WB) r_retire_cnt <= r_retire_cnt + 64'd1;
        end
    end

    assign bus.ifu_req    = (r_state == S_FETCH);
    assign bus.lsu_req    = (r_state == S_MEM);
    assign bus.ir_we      = (r_state == S_FETCH) & bus.ifu_ack;
    assign bus.pc_we      = (r_state == S_WB);
    assign bus.rf_we      = (r_state == S_WB) & ~r_store_op;
    assign bus.halted     = (r_state == S_HALT);
    assign bus.halt_code  = r_halt_code;
    assign bus.state      = r_state;
    assign bus.retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_ysyx_22040237_seq_ctrl.sv
// Directed bench for the NPC sequencer: one-instruction vector table plus stream, halt and reset sequences.
module tb_ysyx_22040237_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_22040237_seq_ctrl_if bus();

    ysyx_22040237_seq_ctrl #(.TIMEOUT_W(8), .TIMEOUT(255)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int excl_viol = 0;

    always @(negedge clk) if (bus.ifu_req && bus.lsu_req) excl_viol++;

    typedef struct {
        string    name;
        logic     ld, st, ebrk, inv;
        int       ifu_dly, lsu_dly;
        int       exp_cyc;
        logic [1:0] exp_code;
        logic     exp_rf;
        logic     exp_ret;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.ifu_ack = 0; bus.lsu_ack = 0;
        bus.inst_is_load = 0; bus.inst_is_store = 0; bus.inst_ebreak = 0; bus.invalid_inst = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // IDLE -> FETCH with a one-cycle start pulse; returns at the negedge after entry
    task automatic kick();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, fw, mw;
        logic [2:0] st;
        logic wb_rf, wb_pc;
        cyc = 0; fw = 0; mw = 0; wb_rf = 0; wb_pc = 0;
        do_reset();
        bus.inst_is_load = v.ld; bus.inst_is_store = v.st;
        bus.inst_ebreak = v.ebrk; bus.invalid_inst = v.inv;
        kick();
        do begin
            st = bus.state;
            bus.ifu_ack = (st == 3'd1) && (fw == v.ifu_dly);
            bus.lsu_ack = (st == 3'd4) && (mw == v.lsu_dly);
            if (st == 3'd1) fw++;
            if (st == 3'd4) mw++;
            #1;
            if (st == 3'd5) begin wb_rf = bus.rf_we; wb_pc = bus.pc_we; end
            step();
            cyc++;
        end while (!((bus.state == 3'd1 && st == 3'd5) || bus.state == 3'd6) && cyc < 600);
        bus.ifu_ack = 0; bus.lsu_ack = 0;
        chk({v.name, ".cycles"},    cyc,            v.exp_cyc);
        chk({v.name, ".halt_code"}, bus.halt_code,  v.exp_code);
        chk({v.name, ".halted"},    bus.halted,     v.exp_code != 2'd0);
        chk({v.name, ".rf_we"},     wb_rf,          v.exp_rf);
        chk({v.name, ".pc_we"},     wb_pc,          v.exp_ret);
        chk({v.name, ".retire"},    bus.retire_cnt, {63'd0, v.exp_ret});
    endtask

    initial begin
        int n;
        logic [11:0] pc_pat, ir_pat;
        logic [63:0] rc;

        //          name        ld st eb inv ifu lsu cyc code rf ret
        vecs[0] = '{"alu",       0, 0, 0, 0,  0,  0,  4, 0, 1, 1};
        vecs[1] = '{"load",      1, 0, 0, 0,  0,  0,  5, 0, 1, 1};
        vecs[2] = '{"store_d3",  0, 1, 0, 0,  0,  3,  8, 0, 0, 1};
        vecs[3] = '{"alu_if2",   0, 0, 0, 0,  2,  0,  6, 0, 1, 1};
        vecs[4] = '{"load_d12",  1, 0, 0, 0,  1,  2,  8, 0, 1, 1};
        vecs[5] = '{"ebreak",    0, 0, 1, 0,  0,  0,  2, 1, 0, 0};
        vecs[6] = '{"inv_ebrk",  0, 0, 1, 1,  0,  0,  2, 2, 0, 0};
        vecs[7] = '{"ld_and_st", 1, 1, 0, 0,  0,  0,  2, 2, 0, 0};
        vecs[8] = '{"ifu_ack256",0, 0, 0, 0,255,  0,259, 0, 1, 1};
        vecs[9] = '{"lsu_tmo",   0, 1, 0, 0,  0,999,259, 3, 0, 0};

        // reset state
        clear_inputs();
        @(negedge clk);
        chk("rst.state",   bus.state,      3'd0);
        chk("rst.ifu_req", bus.ifu_req,    1'b0);
        chk("rst.pc_we",   bus.pc_we,      1'b0);
        chk("rst.halted",  bus.halted,     1'b0);
        chk("rst.code",    bus.halt_code,  2'd0);
        chk("rst.retire",  bus.retire_cnt, 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // ALU stream with ifu_ack tied high
        do_reset();
        bus.ifu_ack = 1'b1;
        kick();
        pc_pat = '0; ir_pat = '0;
        for (int c = 0; c < 12; c++) begin
            #1;
            pc_pat[c] = bus.pc_we;
            ir_pat[c] = bus.ir_we;
            step();
        end
        chk("stream.pc_we_pat", pc_pat, 12'h888);
        chk("stream.ir_we_pat", ir_pat, 12'h111);
        chk("stream.retire",    bus.retire_cnt, 64'd3);
        bus.ifu_ack = 1'b0;

        // ebreak halt is sticky: later start ignored, retire frozen
        do_reset();
        bus.ifu_ack = 1'b1;
        kick();
        repeat (4) step();
        rc = bus.retire_cnt;
        bus.inst_ebreak = 1'b1;
        step();                     // FETCH
        bus.ifu_ack = 1'b0;
        step();                     // DECODE
        chk("ebrk.halt_next", bus.state, 3'd6);
        bus.inst_ebreak = 1'b0;
        bus.start = 1'b1;
        repeat (3) step();
        bus.start = 1'b0;
        chk("ebrk.sticky",    bus.state,      3'd6);
        chk("ebrk.code",      bus.halt_code,  2'd1);
        chk("ebrk.retire",    bus.retire_cnt, rc);
        chk("ebrk.no_req",    bus.ifu_req,    1'b0);

        // fetch watchdog: no ack ever
        do_reset();
        kick();
        n = 0;
        while (bus.state == 3'd1 && n < 1000) begin step(); n++; end
        chk("tmo.fetch_cycles", n,             256);
        chk("tmo.state",        bus.state,     3'd6);
        chk("tmo.code",         bus.halt_code, 2'd3);

        // async reset in MEM
        do_reset();
        bus.inst_is_store = 1'b1;
        bus.ifu_ack = 1'b1;
        kick();
        step();
        bus.ifu_ack = 1'b0;
        step(); step();
        chk("arst.lsu_req_before", bus.lsu_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst.lsu_req", bus.lsu_req,    1'b0);
        chk("arst.state",   bus.state,      3'd0);
        chk("arst.pc_we",   bus.pc_we,      1'b0);
        chk("arst.retire",  bus.retire_cnt, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        chk("req_exclusive", excl_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_22040237_seq_ctrl.md
Name: ysyx_22040237_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the NPC core. It steps each instruction through fetch, decode, execute, optional memory access and writeback. It produces the IFU/LSU request handshakes and the IR/regfile/PC write strobes. It stops the core permanently on ebreak, an invalid instruction, or a memory-ack timeout.

Parameters:
TIMEOUT_W, 8, width of the memory-wait watchdog counter
TIMEOUT, 255, number of un-acked wait cycles in FETCH or MEM that forces a halt; must be below 2^TIMEOUT_W

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  leave IDLE and begin fetching; ignored in every other state
ifu_req  out  1  instruction fetch request
ifu_ack  in  1  instruction valid from IFU
inst_is_load  in  1  decoded load; sampled in DECODE
inst_is_store  in  1  decoded store; sampled in DECODE
inst_ebreak  in  1  decoded ebreak; sampled in DECODE
invalid_inst  in  1  decode found no legal opcode; sampled in DECODE
lsu_req  out  1  data memory request
lsu_ack  in  1  data memory done
ir_we  out  1  latch instruction register
rf_we  out  1  register file write enable
pc_we  out  1  PC update enable (PC takes pc_jump_addr or pc+4 externally)
halted  out  1  core stopped
halt_code  out  2  0 running, 1 ebreak, 2 invalid instruction, 3 timeout
state  out  3  current state encoding, for debug
retire_cnt  out  64  count of retired instructions

Behaviour:
- Reset: while rst is low, go asynchronously to IDLE. All outputs are 0 and retire_cnt is 0. The mem_op, store_op and wait counter registers are cleared.
- Reset mid-operation: ifu_req and lsu_req drop in the same cycle rst falls; no strobe is issued.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: start=1 moves to FETCH.
- FETCH: ifu_req=1 (Moore output).
  - If ifu_ack=1: ir_we=1 in that cycle (Mealy output), then move to DECODE.
  - Otherwise the wait counter increments.
- DECODE: one cycle. Checks in priority order:
  - invalid_inst, or inst_is_load and inst_is_store both high: move to HALT with code 2.
  - inst_ebreak: move to HALT with code 1.
  - Otherwise move to EXEC. Latch mem_op = load OR store and store_op = store.
- EXEC: one cycle, lets the combinational EXU result settle. Move to MEM if mem_op is set, else to WB.
- MEM: lsu_req=1. Move to WB on lsu_ack; otherwise the wait counter increments.
- WB: one cycle.
  - pc_we=1.
  - rf_we = NOT store_op.
  - retire_cnt increments by 1 and wraps modulo 2^64.
  - Move to FETCH.
- Watchdog:
  - The counter clears on every entry to FETCH or MEM.
  - If the counter equals TIMEOUT while still waiting with no ack, move to HALT with code 3.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and the normal transition is taken.
- HALT: sticky until reset. halted=1 and halt_code is held. All requests and strobes are 0; retire_cnt is frozen.
- Latency with zero-wait acks: ALU instruction 4 cycles (FETCH, DECODE, EXEC, WB); load/store 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Strobe pulses last exactly one cycle.
- ifu_req and lsu_req are never high together.

Test Plan:
- Reset held, then released with start=1 for one cycle and ifu_ack tied high. Required: ALU instructions retire; pc_we pulses every 4 cycles; retire_cnt=3 after 12 cycles past FETCH entry.
- Store instruction, lsu_ack delayed 3 cycles. Required: lsu_req high for 4 cycles; then WB with pc_we=1 and rf_we=0; instruction takes 8 cycles total.
- inst_ebreak=1 in DECODE. Required: HALT next cycle, halted=1, halt_code=1, retire_cnt unchanged. A later start has no effect.
- invalid_inst and inst_ebreak both high in DECODE. Required: halt_code=2. Separately, load and store both high also gives halt_code=2.
- ifu_ack never asserted. Required: HALT with halt_code=3 after 256 FETCH cycles (TIMEOUT=255). A second run with ack on the 256th cycle proceeds to DECODE.
- rst pulled low during MEM with lsu_req=1. Required: lsu_req=0 and state=0 immediately, without waiting for a clock edge.
